// File: rtl/ext_ram_pkg.sv
// Shared types for the working-RAM scheduler.
// FSM state codes, grant encoding and default widths.
package ext_ram_pkg;

   localparam int DATA_W_DEF = 128;
   localparam int ADDR_W_DEF = 8;

   typedef logic [1:0] state_t;
   localparam state_t IDLE  = 2'd0;
   localparam state_t RUN   = 2'd1;
   localparam state_t DRAIN = 2'd2;

   typedef enum logic [1:0] {
      G_NONE,
      G_HWR,
      G_CORE,
      G_HRD
   } grant_e;

endpackage

// File: rtl/ext_ram_scheduler_if.sv
// Bus bundle between the scheduler and its host/core/RAM neighbours.
// slave: the scheduler side; master: the environment side.
interface ext_ram_if
   import ext_ram_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
);
   logic              host_wr_en;
   logic [ADDR_W-1:0] host_wr_addr;
   logic [DATA_W-1:0] host_wr_data;
   logic [ADDR_W-1:0] host_rd_addr;
   logic [DATA_W-1:0] host_rd_data;
   logic              run;
   logic              swrst;
   logic              core_req;
   logic              core_we;
   logic [ADDR_W-1:0] core_addr;
   logic [DATA_W-1:0] core_wdata;
   logic              core_gnt;
   logic              core_rvalid;
   logic [DATA_W-1:0] core_rdata;
   logic              core_start;
   logic              core_done;
   logic              busy;
   logic              err_ovf;
   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   modport slave (
      input  host_wr_en, host_wr_addr, host_wr_data, host_rd_addr,
      input  run, swrst, core_req, core_we, core_addr, core_wdata,
      input  core_done, ram_rdata,
      output host_rd_data, core_gnt, core_rvalid, core_rdata,
      output core_start, busy, err_ovf,
      output ram_en, ram_we, ram_addr, ram_wdata
   );

   modport master (
      output host_wr_en, host_wr_addr, host_wr_data, host_rd_addr,
      output run, swrst, core_req, core_we, core_addr, core_wdata,
      output core_done, ram_rdata,
      input  host_rd_data, core_gnt, core_rvalid, core_rdata,
      input  core_start, busy, err_ovf,
      input  ram_en, ram_we, ram_addr, ram_wdata
   );

endinterface

// File: rtl/ext_ram_scheduler_arb.sv
// Per-cycle RAM port arbiter: host write, core access, host read.
// With ARB_FAIR_EN, host write and core alternate when both contend.
module ext_ram_arb
   import ext_ram_pkg::*;
(
   input  logic   pend_vld_i,
   input  logic   core_req_i,
   input  state_t state_i,
`ifdef ARB_FAIR_EN
   input  logic   last_core_i,
   output logic   last_core_o,
`endif
   output grant_e grant_o
);

   logic hw, cw, hr;
   logic host_first;
   logic hw_win, core_win, rd_win;

   always_comb begin
      hw = pend_vld_i;
      cw = core_req_i && (state_i == RUN);
      hr = (state_i == IDLE);
`ifdef ARB_FAIR_EN
      host_first = !(hw && cw) || last_core_i;
`else
      host_first = 1'b1;
`endif
      hw_win   = hw && host_first;
      core_win = cw && !hw_win;
      rd_win   = hr && !hw;
      grant_o  = G_NONE;
      unique case (1'b1)
         hw_win:   grant_o = G_HWR;
         core_win: grant_o = G_CORE;
         rd_win:   grant_o = G_HRD;
         default:  grant_o = G_NONE;
      endcase
`ifdef ARB_FAIR_EN
      last_core_o = core_win ? 1'b1 : (hw_win ? 1'b0 : last_core_i);
`endif
   end

endmodule

// File: rtl/ext_ram_scheduler.sv
// Shares one sync-read RAM between host bus and core; sequences sessions.
// Define ARB_FAIR_EN for round-robin host-write/core arbitration.
module ext_ram_scheduler
   import ext_ram_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
)(
   input logic clk,
   input logic rst_n,
   ext_ram_if.slave bus
);

   state_t            state_q, state_d;
   logic              pend_q, pend_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic [DATA_W-1:0] pdata_q, pdata_d;
   logic              ovf_q, ovf_d;
   logic              rvalid_q, rvalid_d;
   logic              hrd_q, hrd_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   grant_e            arb_gnt, gnt;
   logic              drain;

`ifdef ARB_FAIR_EN
   logic last_core_q, last_core_d;
`endif

   ext_ram_arb u_arb (
      .pend_vld_i  (pend_q),
      .core_req_i  (bus.core_req),
      .state_i     (state_q),
`ifdef ARB_FAIR_EN
      .last_core_i (last_core_q),
      .last_core_o (last_core_d),
`endif
      .grant_o     (arb_gnt)
   );

   // No RAM strobe may escape while reset is held.
   assign gnt   = rst_n ? arb_gnt : G_NONE;
   assign drain = (gnt == G_HWR);

   always_comb begin
      pend_d  = pend_q;
      paddr_d = paddr_q;
      pdata_d = pdata_q;
      ovf_d   = ovf_q;
      if (bus.host_wr_en && pend_q && !drain) begin
         ovf_d = 1'b1;
      end else if (bus.host_wr_en) begin
         pend_d  = 1'b1;
         paddr_d = bus.host_wr_addr;
         pdata_d = bus.host_wr_data;
      end else if (drain) begin
         pend_d = 1'b0;
      end
      if (bus.swrst) pend_d = 1'b0;
      rvalid_d = (gnt == G_CORE) && !bus.core_we && !bus.swrst;
      hrd_d    = (gnt == G_HRD);
      hold_d   = hrd_q ? bus.ram_rdata : hold_q;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.run) state_d = RUN;
         RUN:     if (bus.core_done) state_d = DRAIN;
         DRAIN:   if (!rvalid_q && !pend_q) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (bus.swrst) state_d = IDLE;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         pend_q   <= 1'b0;
         paddr_q  <= '0;
         pdata_q  <= '0;
         ovf_q    <= 1'b0;
         rvalid_q <= 1'b0;
         hrd_q    <= 1'b0;
         hold_q   <= '0;
      end else begin
         state_q  <= state_d;
         pend_q   <= pend_d;
         paddr_q  <= paddr_d;
         pdata_q  <= pdata_d;
         ovf_q    <= ovf_d;
         rvalid_q <= rvalid_d;
         hrd_q    <= hrd_d;
         hold_q   <= hold_d;
      end
   end

`ifdef ARB_FAIR_EN
   // Starts as "core won last" so the host takes the first contest.
   always_ff @(posedge clk) begin
      if (!rst_n) last_core_q <= 1'b1;
      else        last_core_q <= last_core_d;
   end
`endif

   always_comb begin
      bus.ram_addr  = '0;
      bus.ram_wdata = '0;
      case (gnt)
         G_HWR: begin
            bus.ram_addr  = paddr_q;
            bus.ram_wdata = pdata_q;
         end
         G_CORE: begin
            bus.ram_addr  = bus.core_addr;
            bus.ram_wdata = bus.core_wdata;
         end
         G_HRD:   bus.ram_addr = bus.host_rd_addr;
         default: bus.ram_addr = '0;
      endcase
   end

   assign bus.ram_en  = (gnt != G_NONE);
   assign bus.ram_we  = drain || ((gnt == G_CORE) && bus.core_we);
   assign bus.core_gnt = (gnt == G_CORE);
   assign bus.core_start = rst_n && bus.run && !bus.swrst
                           && (state_q == IDLE);
   assign bus.busy        = (state_q != IDLE);
   assign bus.err_ovf     = ovf_q;
   assign bus.core_rvalid = rvalid_q;
   assign bus.core_rdata  = rvalid_q ? bus.ram_rdata : '0;
   assign bus.host_rd_data = hrd_q ? bus.ram_rdata : hold_q;

endmodule

// File: tb/tb_ext_ram_scheduler.sv
// Bench for ext_ram_scheduler: directed scenarios plus random traffic
// checked every cycle against a behavioural scheduler model.
module tb_ext_ram_scheduler;

   logic clk = 1'b0;
   logic rst_n;
   int   n_chk = 0;
   int   n_err = 0;

   localparam logic [127:0] D1 = 128'h1122_3344_5566_7788_99aa_bbcc_ddee_ff00;
   localparam logic [127:0] D2 = 128'hcafe_0000_1234_5678_dead_beef_0bad_f00d;

   always #5 clk = ~clk;

   ext_ram_if #(.DATA_W(128), .ADDR_W(8)) bus ();

   ext_ram_scheduler dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Behavioural RAM: synchronous read, holds data between reads.
   bit   [127:0] ram [256];
   logic [127:0] ram_q = '0;
   assign bus.ram_rdata = ram_q;
   always @(posedge clk) begin
      if (bus.ram_en) begin
         if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
         else            ram_q <= ram[bus.ram_addr];
      end
   end

   // Reference model state (mode: 0 idle, 1 run, 2 drain)
   int       m_mode = 0;
   bit       m_pend = 0;
   bit [7:0] m_paddr = 0;
   bit [127:0] m_pdata = 0;
   bit       m_err = 0;
   bit       m_rv = 0;
   bit [127:0] m_crd = 0;
   bit [127:0] m_hrd = 0;
   bit       m_host_last = 0;
   bit [127:0] exp_mem [256];

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
      end
   endtask

   // Who owns the RAM port this cycle: 0 none, 1 host wr, 2 core, 3 host rd
   function automatic int mgrant();
      bit hw, cw, host_takes;
      if (!rst_n) return 0;
      hw = m_pend;
      cw = bus.core_req && (m_mode == 1);
`ifdef ARB_FAIR_EN
      host_takes = hw && (!cw || !m_host_last);
`else
      host_takes = hw;
`endif
      if (host_takes) return 1;
      if (cw) return 2;
      if (m_mode == 0) return 3;
      return 0;
   endfunction

   task automatic compare();
      int g = mgrant();
      logic [7:0] ea;
      ea = (g == 1) ? m_paddr : (g == 2) ? bus.core_addr :
           (g == 3) ? bus.host_rd_addr : 8'h00;
      chk("ram_en", bus.ram_en, g != 0);
      chk("ram_we", bus.ram_we, g == 1 || (g == 2 && bus.core_we));
      chk("ram_addr", bus.ram_addr, ea);
      if (g == 1) chk("ram_wdata_h", bus.ram_wdata, m_pdata);
      if (g == 2 && bus.core_we)
         chk("ram_wdata_c", bus.ram_wdata, bus.core_wdata);
      chk("core_gnt", bus.core_gnt, g == 2);
      chk("core_start", bus.core_start,
          rst_n && bus.run && !bus.swrst && m_mode == 0);
      chk("busy", bus.busy, m_mode != 0);
      chk("err_ovf", bus.err_ovf, m_err);
      chk("core_rvalid", bus.core_rvalid, m_rv);
      if (m_rv) chk("core_rdata", bus.core_rdata, m_crd);
      chk("host_rd_data", bus.host_rd_data, m_hrd);
   endtask

   task automatic advance();
      int g = mgrant();
      if (!rst_n) begin
         m_mode = 0; m_pend = 0; m_err = 0; m_rv = 0;
         m_hrd = 0; m_host_last = 0;
         return;
      end
      if (g == 3) m_hrd = exp_mem[bus.host_rd_addr];
      if (g == 2 && !bus.core_we) m_crd = exp_mem[bus.core_addr];
      if (bus.swrst) m_mode = 0;
      else if (m_mode == 0 && bus.run) m_mode = 1;
      else if (m_mode == 1 && bus.core_done) m_mode = 2;
      else if (m_mode == 2 && !m_rv && !m_pend) m_mode = 0;
      m_rv = (g == 2) && !bus.core_we && !bus.swrst;
      if (g == 1) begin
         exp_mem[m_paddr] = m_pdata;
         m_host_last = 1;
      end
      if (g == 2) begin
         m_host_last = 0;
         if (bus.core_we) exp_mem[bus.core_addr] = bus.core_wdata;
      end
      if (bus.host_wr_en) begin
         if (m_pend && g != 1) m_err = 1;
         else begin
            m_pend = 1; m_paddr = bus.host_wr_addr;
            m_pdata = bus.host_wr_data;
         end
      end else if (g == 1) m_pend = 0;
      if (bus.swrst) m_pend = 0;
   endtask

   task automatic tick();
      @(negedge clk);
      compare();
      @(posedge clk);
      advance();
      #1;
   endtask

   task automatic quiet();
      bus.host_wr_en = 0; bus.host_wr_addr = 0; bus.host_wr_data = 0;
      bus.run = 0; bus.swrst = 0; bus.core_req = 0; bus.core_we = 0;
      bus.core_addr = 0; bus.core_wdata = 0; bus.core_done = 0;
   endtask

   task automatic host_wr(input logic [7:0] a, input logic [127:0] d);
      bus.host_wr_en = 1; bus.host_wr_addr = a; bus.host_wr_data = d;
   endtask

   initial begin
      rst_n = 0;
      quiet();
      bus.host_rd_addr = 0;
      @(posedge clk);
      advance();
      #1;
      tick();
      rst_n = 1;
      tick();

      // host write then read in IDLE
      host_wr(8'h05, D1);
      tick();
      bus.host_wr_en = 0;
      tick();
      bus.host_rd_addr = 8'h05;
      tick();
      tick();
      chk("t1_host_rd", bus.host_rd_data, D1);

      // session: start, core read, done, drain
      bus.run = 1;
      tick();
      bus.run = 0;
      chk("t2_busy_on", bus.busy, 1'b1);
      bus.core_req = 1; bus.core_we = 0; bus.core_addr = 8'h05;
      tick();
      bus.core_req = 0;
      chk("t2_rvalid", bus.core_rvalid, 1'b1);
      chk("t2_rdata", bus.core_rdata, D1);
      bus.core_done = 1;
      tick();
      bus.core_done = 0;
      tick();
      chk("t2_busy_off", bus.busy, 1'b0);

      // collision: core held while host write arrives
      bus.run = 1;
      tick();
      bus.run = 0;
      bus.core_req = 1; bus.core_we = 1; bus.core_addr = 8'h21;
      bus.core_wdata = 128'h77;
      host_wr(8'h30, D2);
      tick();
      bus.host_wr_en = 0;
      #1;
      chk("t3_core_blocked", bus.core_gnt, 1'b0);
      repeat (4) tick();
      bus.core_req = 0; bus.core_done = 1;
      tick();
      bus.core_done = 0;
      repeat (3) tick();

`ifdef ARB_FAIR_EN
      // overflow: core wins the round after a host win, second write lost
      bus.run = 1;
      tick();
      bus.run = 0;
      host_wr(8'h40, 128'h40);
      tick();
      host_wr(8'h41, 128'h41);
      bus.core_req = 1; bus.core_we = 0; bus.core_addr = 8'h05;
      tick();
      host_wr(8'h42, 128'h42);
      tick();
      bus.host_wr_en = 0;
      tick();
      chk("t4_ovf_set", bus.err_ovf, 1'b1);
      bus.core_req = 0; bus.swrst = 1;
      tick();
      bus.swrst = 0;
      tick();
      chk("t4_ovf_sticky", bus.err_ovf, 1'b1);
`endif

      // abort with a core read in flight
      bus.run = 1;
      tick();
      bus.run = 0;
      bus.core_req = 1; bus.core_we = 0; bus.core_addr = 8'h05;
      bus.swrst = 1;
      tick();
      bus.core_req = 0; bus.swrst = 0;
      chk("t5_busy", bus.busy, 1'b0);
      chk("t5_no_rvalid", bus.core_rvalid, 1'b0);
      bus.host_rd_addr = 8'h30;
      tick();
      tick();
      chk("t5_host_rd", bus.host_rd_data, D2);

      // reset in the cycle after a host write strobe
      host_wr(8'h50, 128'h5050);
      tick();
      bus.host_wr_en = 0;
      rst_n = 0;
      #1;
      chk("t6_no_we", bus.ram_we, 1'b0);
      tick();
      tick();
      chk("t6_rd_zero", bus.host_rd_data, 128'h0);
      chk("t6_busy_zero", bus.busy, 1'b0);
      rst_n = 1;
      bus.host_rd_addr = 8'h50;
      tick();
      tick();
      chk("t6_write_lost", bus.host_rd_data, 128'h0);

      // random traffic
      for (int i = 0; i < 2500; i++) begin
         rst_n = ($urandom_range(0, 299) != 0);
         bus.host_wr_en   = ($urandom_range(0, 9) < 3);
         bus.host_wr_addr = 8'($urandom_range(0, 15));
         bus.host_wr_data = {$urandom, $urandom, $urandom, $urandom};
         bus.host_rd_addr = 8'($urandom_range(0, 15));
         bus.run          = ($urandom_range(0, 19) == 0);
         bus.swrst        = ($urandom_range(0, 49) == 0);
         bus.core_req     = ($urandom_range(0, 1) == 1);
         bus.core_we      = ($urandom_range(0, 2) == 0);
         bus.core_addr    = 8'($urandom_range(0, 15));
         bus.core_wdata   = {$urandom, $urandom, $urandom, $urandom};
         bus.core_done    = ($urandom_range(0, 19) == 0);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/ext_ram_scheduler.md
Name: ext_ram_scheduler

Overview:
- Owns one single-port, synchronous-read working RAM and shares it between two requesters: the host side (UART controller ext bus) and the generator core.
- Also sequences core sessions. A run pulse starts a session, core_done ends it, and a swrst pulse aborts it.
- Sits between the UART controller outputs (addr_extin/extin_data/extin_en/addr_extout/extout_data/run/swrst) and the core/RAM.

Parameters:
- DATA_W, 128, RAM word width; equals the UART controller len_din/len_dout.
- ADDR_W, 8, RAM address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- host_wr_en  in  1  one-cycle write strobe (from extin_en)
- host_wr_addr  in  ADDR_W  write address (addr_extin)
- host_wr_data  in  DATA_W  write data (extin_data)
- host_rd_addr  in  ADDR_W  continuous read address (addr_extout)
- host_rd_data  out  DATA_W  read data to extout_data
- run  in  1  one-cycle session start
- swrst  in  1  one-cycle abort
- core_req  in  1  core access request
- core_we  in  1  core write
- core_addr  in  ADDR_W  core address
- core_wdata  in  DATA_W  core write data
- core_gnt  out  1  core access accepted this cycle
- core_rvalid  out  1  core_rdata valid
- core_rdata  out  DATA_W  core read data
- core_start  out  1  one-cycle session start pulse to core
- core_done  in  1  core session finished
- busy  out  1  session active
- err_ovf  out  1  sticky: host write lost
- ram_en, ram_we  out  1  RAM strobes
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, 1 cycle after ram_en

Behaviour:
- Reset values:
  - FSM is IDLE.
  - All outputs are 0, including host_rd_data, err_ovf and busy.
  - The pending-write register is empty.
- Host write path:
  - host_wr_en loads a 1-entry pending register {addr, data}.
  - The pending register drains to RAM when it wins arbitration.
  - If host_wr_en arrives while the register is still full and it does not drain in that same cycle, the new write is dropped and err_ovf is set.
  - If the register drains in the same cycle that host_wr_en arrives, the new write is accepted.
- Arbitration, once per cycle, in priority order:
  1. pending host write;
  2. core_req, only while in RUN;
  3. host read, only while in IDLE.
  - The RAM port is idle otherwise.
- Grant outputs:
  - ram_* are combinational from the grant.
  - core_gnt is combinational and equals core_req & granted.
- Core reads: core_rvalid is a registered pulse one cycle after a granted core read, with core_rdata = ram_rdata.
- Host reads:
  - In IDLE, when no write is pending, the block reads host_rd_addr every cycle.
  - A registered flag marks a host read issued in the previous cycle. While that flag is set, host_rd_data = ram_rdata; otherwise host_rd_data holds the last captured value.
  - Result: data for a new address is valid 2 edges after the address changes. This meets the UART controller's one-cycle RAM-wait.
- FSM:
  - IDLE --run--> RUN, emitting a core_start pulse in that transition cycle. busy=1 in RUN and DRAIN.
  - RUN --core_done--> DRAIN.
  - DRAIN waits until no core read is outstanding and the pending register is empty, then goes to IDLE.
  - run in RUN or DRAIN is ignored.
  - swrst in any state goes to IDLE. It clears the pending write and core_rvalid, and does not clear err_ovf.
  - swrst has priority over run in the same cycle.
  - err_ovf clears only on rst_n.
- Simultaneous run and host_wr_en: both are accepted.
- Reset mid-operation: all state is discarded and no RAM strobe is issued in the reset cycle.

Optional Feature:
- Macro ARB_FAIR_EN.
- When defined, the pending host write and core_req alternate round-robin when both request in RUN. A 1-bit last-winner register resets to "core", so the host wins first. Worst case, the pending write waits 1 cycle.
- When undefined, host writes take fixed priority, as described above.

Decomposition:
- Shared package ext_ram_pkg:
  - FSM state enum: IDLE, RUN, DRAIN;
  - grant enum: G_NONE, G_HWR, G_CORE, G_HRD;
  - default width constants.
- One sub-module, ext_ram_arb: the combinational/round-robin grant logic. Its inputs are pending-valid, core_req and state; its outputs are the grant and the last-winner update.

Test Plan:
- Host write then read, in IDLE:
  - Stimulus: host_wr_en at addr 0x05 with data 0x1122…, then host_rd_addr=0x05.
  - Required: ram_we at addr 0x05 in the cycle after the strobe; host_rd_data=0x1122… 2 edges after the address change.
- Session sequencing:
  - run → core_start pulse and busy=1.
  - Core read of addr 0x05 → core_rvalid 1 cycle after grant, core_rdata=0x1122….
  - core_done → DRAIN → IDLE → busy=0.
- Collision during RUN:
  - core_req held continuously while host_wr_en arrives.
  - Without ARB_FAIR_EN: host wins the next cycle and core_gnt=0 for exactly that cycle.
  - With ARB_FAIR_EN: same stimulus gives alternating grants.
- Overflow:
  - Two host_wr_en 1 cycle apart in RUN under ARB_FAIR_EN, with the core winning the first round.
  - Required: second write dropped, err_ovf=1 and stays 1 after swrst.
- Abort:
  - swrst during RUN with a core read outstanding.
  - Required: next cycle state is IDLE, busy=0, no core_rvalid, and host reads resume.
- Reset mid-write:
  - rst_n low in the cycle after host_wr_en.
  - Required: no ram_we, all outputs 0.
